// File: rtl/mxrv_pc_gen.sv
// Fetch PC generator: BOOT/RUN/HOLD sequencing, trap/jump redirect, ready/valid fetch handshake.
// Optional misaligned-jump rejection with a misalign_o pulse when MXRV_PC_ALIGN_CHK_EN is defined.
module mxrv_pc_gen #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                STEP     = 4,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_flag_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              pc_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
`ifdef MXRV_PC_ALIGN_CHK_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_in_boot;
    logic               w_trap;
    logic               w_jump;
    logic               w_redirect;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_jump_tgt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Redirects are masked in BOOT; trap outranks jump.
    assign w_in_boot  = (r_state == BOOT);
    assign w_trap     = trap_flag_i & ~w_in_boot;
    assign w_jump     = jump_flag_i & ~trap_flag_i & ~w_in_boot;
    assign w_redirect = w_trap | w_jump;
    assign w_jump_tgt = jump_addr_i & ALIGN_MASK;

    assign pc_valid_o  = (r_state == RUN) & ~hold_flag_i & ~jump_flag_i & ~trap_flag_i;
    assign w_accept    = pc_valid_o & pc_ready_i;
    assign pc_o        = r_pc;
    assign fetch_cnt_o = r_cnt;

    // A redirect is the single action of its cycle, so it also suppresses hold entry/exit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN:  if (hold_flag_i && !w_redirect) w_state_nxt = HOLD;
            HOLD: if (!hold_flag_i && !w_redirect) w_state_nxt = RUN;
            default: w_state_nxt = BOOT;
        endcase
    end

`ifdef MXRV_PC_ALIGN_CHK_EN
    logic w_jump_mis;
    logic r_misalign;

    assign w_jump_mis = |jump_addr_i[1:0];
    assign misalign_o = r_misalign;

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_trap) begin
            w_pc_nxt = trap_addr_i;
        end else if (w_jump) begin
            if (!w_jump_mis) w_pc_nxt = w_jump_tgt;
        end else if (w_accept) begin
            w_pc_nxt = r_pc + STEP_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_jump & w_jump_mis;
        end
    end
`else
    always_comb begin
        w_pc_nxt = r_pc;
        if (w_trap) begin
            w_pc_nxt = trap_addr_i;
        end else if (w_jump) begin
            w_pc_nxt = w_jump_tgt;
        end else if (w_accept) begin
            w_pc_nxt = r_pc + STEP_INC;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_accept) r_cnt <= sat_inc(r_cnt);
        end
    end

endmodule

// File: tb/tb_mxrv_pc_gen.sv
// Directed bench for mxrv_pc_gen; a second instance with a 2-bit counter exercises saturation.
// Builds with or without MXRV_PC_ALIGN_CHK_EN.
module tb_mxrv_pc_gen;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        hold  = 1'b0;
    logic        jump  = 1'b0;
    logic        trap  = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] jaddr = '0;
    logic [31:0] taddr = '0;

    logic [31:0] pc, pc2;
    logic        valid, valid2;
    logic [31:0] cnt;
    logic [1:0]  cnt2;
`ifdef MXRV_PC_ALIGN_CHK_EN
    logic        mis, mis2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mxrv_pc_gen dut (
        .clk(clk), .rst_n(rst_n), .hold_flag_i(hold), .jump_flag_i(jump),
        .jump_addr_i(jaddr), .trap_flag_i(trap), .trap_addr_i(taddr),
        .pc_ready_i(ready), .pc_o(pc), .pc_valid_o(valid), .fetch_cnt_o(cnt)
`ifdef MXRV_PC_ALIGN_CHK_EN
        , .misalign_o(mis)
`endif
    );

    mxrv_pc_gen #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .hold_flag_i(hold), .jump_flag_i(jump),
        .jump_addr_i(jaddr), .trap_flag_i(trap), .trap_addr_i(taddr),
        .pc_ready_i(ready), .pc_o(pc2), .pc_valid_o(valid2), .fetch_cnt_o(cnt2)
`ifdef MXRV_PC_ALIGN_CHK_EN
        , .misalign_o(mis2)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        ready = 1'b1;
        #1;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", valid); end
        step();
        n_checks++; if (pc !== 32'h0 || valid !== 1'b1) begin n_fail++; $display("FAIL run_first: pc %h valid %b want 0 1", pc, valid); end
        step();
        n_checks++; if (pc !== 32'h4 || cnt !== 32'd1) begin n_fail++; $display("FAIL seq_4: pc %h cnt %0d want 4 1", pc, cnt); end
        step();
        n_checks++; if (pc !== 32'h8 || cnt !== 32'd2) begin n_fail++; $display("FAIL seq_8: pc %h cnt %0d want 8 2", pc, cnt); end
        step();
        n_checks++; if (pc !== 32'hC || cnt !== 32'd3) begin n_fail++; $display("FAIL seq_c: pc %h cnt %0d want c 3", pc, cnt); end
    endtask

    task automatic test_backpressure();
        step();
        ready = 1'b0;
        n_checks++; if (pc !== 32'h10 || cnt !== 32'd4) begin n_fail++; $display("FAIL seq_10: pc %h cnt %0d want 10 4", pc, cnt); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (pc !== 32'h10 || cnt !== 32'd4 || valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_%0d: pc %h cnt %0d valid %b want 10 4 1", i, pc, cnt, valid);
            end
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        n_checks++; if (pc !== 32'h20 || cnt !== 32'd8) begin n_fail++; $display("FAIL resume_20: pc %h cnt %0d want 20 8", pc, cnt); end
        n_checks++; if (cnt2 !== 2'd3) begin n_fail++; $display("FAIL cnt_sat: got %0d want 3", cnt2); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            hold = 1'b1;
            #1;
            n_checks++;
            if (valid !== 1'b0 || pc !== 32'h20) begin
                n_fail++; $display("FAIL hold_%0d: valid %b pc %h want 0 20", i, valid, pc);
            end
            step();
        end
        hold = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bubble: valid %b want 0", valid); end
        step();
        n_checks++; if (valid !== 1'b1 || pc !== 32'h20 || cnt !== 32'd8) begin n_fail++; $display("FAIL hold_release: valid %b pc %h cnt %0d want 1 20 8", valid, pc, cnt); end
    endtask

    task automatic test_priority();
        jump = 1'b1; jaddr = 32'h100;
        trap = 1'b1; taddr = 32'h80;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL redirect_valid: valid %b want 0", valid); end
        step();
        jump = 1'b0; trap = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h80 || valid !== 1'b1 || cnt !== 32'd8) begin n_fail++; $display("FAIL trap_wins: pc %h valid %b cnt %0d want 80 1 8", pc, valid, cnt); end
    endtask

    task automatic test_jump_wrap();
        ready = 1'b0;
        jump = 1'b1; jaddr = 32'h200;
        step();
        jump = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL jump_200: pc %h want 200", pc); end
        trap = 1'b1; taddr = 32'hFFFF_FFFC;
        step();
        trap = 1'b0; ready = 1'b1;
        #1;
        n_checks++; if (pc !== 32'hFFFF_FFFC || valid !== 1'b1) begin n_fail++; $display("FAIL trap_top: pc %h valid %b want fffffffc 1", pc, valid); end
        step();
        ready = 1'b0;
        n_checks++; if (pc !== 32'h0 || cnt !== 32'd9) begin n_fail++; $display("FAIL wrap: pc %h cnt %0d want 0 9", pc, cnt); end
        jump = 1'b1; jaddr = 32'h102;
`ifdef MXRV_PC_ALIGN_CHK_EN
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_idle: got %b want 0", mis); end
`endif
        step();
        jump = 1'b0;
        #1;
`ifdef MXRV_PC_ALIGN_CHK_EN
        n_checks++; if (pc !== 32'h0 || mis !== 1'b1) begin n_fail++; $display("FAIL mis_reject: pc %h mis %b want 0 1", pc, mis); end
        step();
        n_checks++; if (pc !== 32'h0 || mis !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: pc %h mis %b want 0 0", pc, mis); end
`else
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL jump_force_align: pc %h want 100", pc); end
`endif
    endtask

    task automatic test_hold_redirect();
        ready = 1'b1;
        hold = 1'b1;
        step();
        jump = 1'b1; jaddr = 32'h300;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL hold_jump_valid: valid %b want 0", valid); end
        step();
        jump = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h300 || valid !== 1'b0) begin n_fail++; $display("FAIL hold_jump: pc %h valid %b want 300 0", pc, valid); end
        hold = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL hold_jump_bubble: valid %b want 0", valid); end
        step();
        n_checks++; if (valid !== 1'b1 || pc !== 32'h300 || cnt !== 32'd9) begin n_fail++; $display("FAIL hold_jump_resume: valid %b pc %h cnt %0d want 1 300 9", valid, pc, cnt); end
    endtask

    task automatic test_reset_mid_hold();
        hold = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h0 || cnt !== 32'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: pc %h cnt %0d valid %b want 0 0 0", pc, cnt, valid); end
        n_checks++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL async_reset_cnt2: got %0d want 0", cnt2); end
    endtask

    task automatic test_boot_ignore();
        hold = 1'b0;
        jump = 1'b1; jaddr = 32'h40;
        trap = 1'b1; taddr = 32'h44;
        #2 rst_n = 1'b1;
        step();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL boot_ignore: pc %h want 0", pc); end
        jump = 1'b0; trap = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL boot_run: valid %b pc %h want 1 0", valid, pc); end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_hold();
        test_priority();
        test_jump_wrap();
        test_hold_redirect();
        test_reset_mid_hold();
        test_boot_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
